// File: rtl/uart_cmd_frame_gen.sv
// rtl/uart_cmd_frame_gen.sv - parallel command to UART byte-frame generator; optional CMD_FRAME_GAP_EN inter-frame gap
module uart_cmd_frame_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CMD_VLD,
  output logic                  CMD_RDY,
  input  logic [1:0]            CMD_TYPE,
  input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [DATA_WIDTH-1:0] CMD_DATA_A,
  input  logic [DATA_WIDTH-1:0] CMD_DATA_B,
  input  logic [3:0]            CMD_FUN,
  output logic [DATA_WIDTH-1:0] BYTE_OUT,
  output logic                  BYTE_VLD,
  input  logic                  BYTE_RDY,
  output logic [1:0]            RSP_BYTES,
  output logic                  FRAME_DONE,
  output logic [7:0]            FRAME_CNT
);

  localparam logic [1:0] T_WR      = 2'b00;
  localparam logic [1:0] T_RD      = 2'b01;
  localparam logic [1:0] T_ALU     = 2'b10;
  localparam logic [1:0] T_ALU_NOP = 2'b11;

  if (DATA_WIDTH < 8 || DATA_WIDTH < ADDR_WIDTH || GAP_CYCLES < 0) begin : g_bad_params
    $error("uart_cmd_frame_gen: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE,
    SEND_CMD,
    SEND_ADDR,
    SEND_A,
    SEND_B,
    SEND_FUN
`ifdef CMD_FRAME_GAP_EN
    , GAP
`endif
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              type_q, type_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d;
  logic [DATA_WIDTH-1:0]   b_q, b_d;
  logic [3:0]              fun_q, fun_d;
  logic [1:0]              rsp_q, rsp_d;
  logic                    done_q, done_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    live_q;
  logic                    last;

`ifdef CMD_FRAME_GAP_EN
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  logic [GW-1:0]           gap_q, gap_d;
`endif

  assign RSP_BYTES  = rsp_q;
  assign FRAME_DONE = done_q;
  assign FRAME_CNT  = cnt_q;

  // Next-state, byte mux and handshake outputs; a byte advances only on BYTE_VLD && BYTE_RDY
  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    addr_d   = addr_q;
    a_d      = a_q;
    b_d      = b_q;
    fun_d    = fun_q;
    rsp_d    = rsp_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    last     = 1'b0;
    CMD_RDY  = 1'b0;
    BYTE_VLD = 1'b0;
    BYTE_OUT = '0;
`ifdef CMD_FRAME_GAP_EN
    gap_d    = gap_q;
`endif
    unique case (state_q)
      IDLE: begin
        CMD_RDY = live_q;
        if (CMD_VLD && live_q) begin
          type_d  = CMD_TYPE;
          addr_d  = CMD_ADDR;
          a_d     = CMD_DATA_A;
          b_d     = CMD_DATA_B;
          fun_d   = CMD_FUN;
          rsp_d   = (CMD_TYPE == T_WR) ? 2'd0 : (CMD_TYPE == T_RD) ? 2'd1 : 2'd2;
          state_d = SEND_CMD;
        end
      end
      SEND_CMD: begin
        BYTE_VLD = 1'b1;
        case (type_q)
          T_WR:    BYTE_OUT = DATA_WIDTH'(8'hAA);
          T_RD:    BYTE_OUT = DATA_WIDTH'(8'hBB);
          T_ALU:   BYTE_OUT = DATA_WIDTH'(8'hCC);
          default: BYTE_OUT = DATA_WIDTH'(8'hDD);
        endcase
        if (BYTE_RDY) begin
          if (type_q == T_ALU)          state_d = SEND_A;
          else if (type_q == T_ALU_NOP) state_d = SEND_FUN;
          else                          state_d = SEND_ADDR;
        end
      end
      SEND_ADDR: begin
        BYTE_VLD = 1'b1;
        BYTE_OUT = DATA_WIDTH'(addr_q);
        if (BYTE_RDY) begin
          if (type_q == T_WR) state_d = SEND_A;
          else                last    = 1'b1;
        end
      end
      SEND_A: begin
        BYTE_VLD = 1'b1;
        BYTE_OUT = a_q;
        if (BYTE_RDY) begin
          if (type_q == T_ALU) state_d = SEND_B;
          else                 last    = 1'b1;
        end
      end
      SEND_B: begin
        BYTE_VLD = 1'b1;
        BYTE_OUT = b_q;
        if (BYTE_RDY) state_d = SEND_FUN;
      end
      SEND_FUN: begin
        BYTE_VLD = 1'b1;
        BYTE_OUT = DATA_WIDTH'(fun_q);
        if (BYTE_RDY) last = 1'b1;
      end
`ifdef CMD_FRAME_GAP_EN
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
`endif
      default: state_d = IDLE;
    endcase
    if (last) begin
      done_d  = 1'b1;
      cnt_d   = cnt_q + 8'd1;
      state_d = IDLE;
`ifdef CMD_FRAME_GAP_EN
      if (GAP_CYCLES > 0) begin
        state_d = GAP;
        gap_d   = GW'(GAP_CYCLES - 1);
      end
`endif
    end
  end

  // State and captured-command registers; reset aborts any frame in flight
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      type_q  <= '0;
      addr_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      fun_q   <= '0;
      rsp_q   <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      live_q  <= 1'b0;
`ifdef CMD_FRAME_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fun_q   <= fun_d;
      rsp_q   <= rsp_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
`ifdef CMD_FRAME_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_cmd_frame_gen.sv
// tb/tb_uart_cmd_frame_gen.sv - self-checking bench for uart_cmd_frame_gen
module tb_uart_cmd_frame_gen;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int G  = 4;
`ifdef CMD_FRAME_GAP_EN
  localparam int GAP_MODEL = G;
`else
  localparam int GAP_MODEL = 0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          CMD_VLD = 1'b0;
  logic          CMD_RDY;
  logic [1:0]    CMD_TYPE = '0;
  logic [AW-1:0] CMD_ADDR = '0;
  logic [DW-1:0] CMD_DATA_A = '0;
  logic [DW-1:0] CMD_DATA_B = '0;
  logic [3:0]    CMD_FUN = '0;
  logic [DW-1:0] BYTE_OUT;
  logic          BYTE_VLD;
  logic          BYTE_RDY = 1'b0;
  logic [1:0]    RSP_BYTES;
  logic          FRAME_DONE;
  logic [7:0]    FRAME_CNT;

  uart_cmd_frame_gen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .GAP_CYCLES(G)) dut (
    .CLK(CLK), .RST(RST), .CMD_VLD(CMD_VLD), .CMD_RDY(CMD_RDY), .CMD_TYPE(CMD_TYPE),
    .CMD_ADDR(CMD_ADDR), .CMD_DATA_A(CMD_DATA_A), .CMD_DATA_B(CMD_DATA_B), .CMD_FUN(CMD_FUN),
    .BYTE_OUT(BYTE_OUT), .BYTE_VLD(BYTE_VLD), .BYTE_RDY(BYTE_RDY), .RSP_BYTES(RSP_BYTES),
    .FRAME_DONE(FRAME_DONE), .FRAME_CNT(FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tmo(input string name);
    nvec++;
    nfail++;
    $display("FAIL %s: timeout waiting for DUT event (t=%0t)", name, $time);
  endtask

  // Model: the frame in flight is a queue of bytes still owed downstream
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] xfer_log[$];
  logic [7:0]    m_cnt = '0;
  logic [1:0]    m_rsp = '0;
  bit            m_done_next = 1'b0;
  bit            m_fresh = 1'b1;
  int            m_gap = 0;
  int            done_seen = 0;

  task automatic model_push(input logic [1:0] t, input logic [AW-1:0] a,
                            input logic [DW-1:0] da, input logic [DW-1:0] db, input logic [3:0] f);
    case (t)
      2'b00: begin exp_q.push_back(DW'(8'hAA)); exp_q.push_back(DW'(a)); exp_q.push_back(da); end
      2'b01: begin exp_q.push_back(DW'(8'hBB)); exp_q.push_back(DW'(a)); end
      2'b10: begin exp_q.push_back(DW'(8'hCC)); exp_q.push_back(da); exp_q.push_back(db); exp_q.push_back(DW'(f)); end
      default: begin exp_q.push_back(DW'(8'hDD)); exp_q.push_back(DW'(f)); end
    endcase
    m_rsp = (t == 2'b00) ? 2'd0 : (t == 2'b01) ? 2'd1 : 2'd2;
  endtask

  // Per-cycle compare against the model, sampled mid-cycle
  always @(negedge CLK) begin
    bit exp_vld;
    bit exp_rdy;
    if (!RST) begin
      chk("rst_cmd_rdy", CMD_RDY, 0);
      chk("rst_byte_vld", BYTE_VLD, 0);
      chk("rst_byte_out", BYTE_OUT, 0);
      chk("rst_rsp_bytes", RSP_BYTES, 0);
      chk("rst_frame_done", FRAME_DONE, 0);
      chk("rst_frame_cnt", FRAME_CNT, 0);
      exp_q.delete();
      m_cnt = '0; m_rsp = '0; m_done_next = 1'b0; m_gap = 0; m_fresh = 1'b1;
    end else begin
      if (m_done_next) m_cnt = m_cnt + 8'd1;
      exp_vld = (exp_q.size() > 0);
      exp_rdy = !exp_vld && (m_gap == 0) && !m_fresh;
      chk("frame_done", FRAME_DONE, m_done_next);
      chk("frame_cnt", FRAME_CNT, m_cnt);
      chk("rsp_bytes", RSP_BYTES, m_rsp);
      chk("byte_vld", BYTE_VLD, exp_vld);
      chk("cmd_rdy", CMD_RDY, exp_rdy);
      if (exp_vld) chk("byte_out", BYTE_OUT, exp_q[0]);
      if (FRAME_DONE) done_seen++;
      m_done_next = 1'b0;
      m_fresh = 1'b0;
      if (m_gap > 0) m_gap--;
      if (exp_vld && BYTE_RDY) begin
        xfer_log.push_back(BYTE_OUT);
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          m_done_next = 1'b1;
          m_gap = GAP_MODEL;
        end
      end
      if (exp_rdy && CMD_VLD) model_push(CMD_TYPE, CMD_ADDR, CMD_DATA_A, CMD_DATA_B, CMD_FUN);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a command and hold it until captured; returns in the first SEND_CMD cycle
  task automatic issue(input logic [1:0] t, input logic [AW-1:0] a,
                       input logic [DW-1:0] da, input logic [DW-1:0] db, input logic [3:0] f);
    int k;
    CMD_TYPE = t; CMD_ADDR = a; CMD_DATA_A = da; CMD_DATA_B = db; CMD_FUN = f;
    CMD_VLD = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge CLK);
      if (CMD_RDY) break;
    end
    if (k == 50) tmo("capture");
    tick();
    CMD_VLD = 1'b0;
    CMD_TYPE = 2'($urandom); CMD_ADDR = AW'($urandom); CMD_FUN = 4'($urandom);
    CMD_DATA_A = DW'($urandom); CMD_DATA_B = DW'($urandom);
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (FRAME_DONE) break;
    end
    if (k == 100) tmo(name);
  endtask

  task automatic chk_log(input string name, input logic [31:0] b0, input logic [31:0] b1,
                         input logic [31:0] b2, input logic [31:0] b3, input int n);
    logic [31:0] e[4];
    e[0] = b0; e[1] = b1; e[2] = b2; e[3] = b3;
    chk({name, "_len"}, xfer_log.size(), n);
    for (int i = 0; i < n && i < xfer_log.size(); i++) chk({name, "_byte"}, xfer_log[i], e[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [6:0] pat;
    int caps, base, bad, k;
    BYTE_RDY = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    chk("rdy_low_first_cycle", CMD_RDY, 0);
    tick();

    // RF write
    xfer_log.delete();
    issue(2'b00, 4'h5, 8'h3C, 8'h00, 4'h0);
    wait_done("wr_done");
    chk_log("wr", 32'hAA, 32'h05, 32'h3C, 0, 3);
    chk("wr_cnt", FRAME_CNT, 1);
    chk("wr_rsp", RSP_BYTES, 0);
`ifndef CMD_FRAME_GAP_EN
    chk("wr_rdy_at_done", CMD_RDY, 1);
`endif
    tick();

    // RF read
    xfer_log.delete();
    issue(2'b01, 4'h2, 8'h99, 8'h00, 4'h0);
    wait_done("rd_done");
    chk_log("rd", 32'hBB, 32'h02, 0, 0, 2);
    chk("rd_rsp", RSP_BYTES, 1);
    chk("rd_cnt", FRAME_CNT, 2);
`ifndef CMD_FRAME_GAP_EN
    tick();
    @(negedge CLK);
    chk("rd_rdy_after_done", CMD_RDY, 1);
`endif
    tick();

    // ALU with operands under a stalling transmitter
    xfer_log.delete();
    issue(2'b10, 4'h0, 8'h12, 8'h34, 4'h3);
    pat = 7'b1001011;
    for (int i = 0; i < 7; i++) begin
      BYTE_RDY = pat[6-i];
      tick();
    end
    BYTE_RDY = 1'b1;
    wait_done("alu_done");
    chk_log("alu", 32'hCC, 32'h12, 32'h34, 32'h03, 4);
    chk("alu_rsp", RSP_BYTES, 2);
    tick();

    // Reset during byte 2 of an ALU-operands frame
    issue(2'b10, 4'h0, 8'hAB, 8'hCD, 4'h5);
    tick();
    RST = 1'b0;
    @(negedge CLK);
    chk("midrst_byte_vld", BYTE_VLD, 0);
    tick();
    RST = 1'b1;
    xfer_log.delete();
    issue(2'b00, 4'h9, 8'h77, 8'h00, 4'h0);
    wait_done("post_rst_done");
    chk_log("post_rst", 32'hAA, 32'h09, 32'h77, 0, 3);
    chk("post_rst_cnt", FRAME_CNT, 1);
    tick();

    // 256 back-to-back ALU-without-operands frames from a fresh reset
    RST = 1'b0;
    tick();
    RST = 1'b1;
    xfer_log.delete();
    base = done_seen;
    caps = 0;
    CMD_TYPE = 2'b11; CMD_FUN = 4'hA; CMD_ADDR = 4'h7; CMD_DATA_A = 8'h55; CMD_DATA_B = 8'h66;
    CMD_VLD = 1'b1;
    for (k = 0; k < 4000; k++) begin
      @(negedge CLK);
      if (CMD_VLD && CMD_RDY) caps++;
      if (caps == 256) break;
    end
    if (k == 4000) tmo("b2b_captures");
    tick();
    CMD_VLD = 1'b0;
    for (k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (done_seen - base == 256) break;
    end
    if (k == 20) tmo("b2b_done");
    chk("b2b_done_pulses", done_seen - base, 256);
    chk("b2b_cnt_wrap", FRAME_CNT, 0);
    chk("b2b_log_len", xfer_log.size(), 512);
    bad = 0;
    for (int i = 0; i < xfer_log.size(); i++)
      if (xfer_log[i] !== ((i % 2 == 0) ? DW'(8'hDD) : DW'(8'h0A))) bad++;
    chk("b2b_bad_bytes", bad, 0);
    tick();

`ifdef CMD_FRAME_GAP_EN
    // Gap length between frames with the feature enabled
    issue(2'b01, 4'h1, 8'h00, 8'h00, 4'h0);
    wait_done("gap_done");
    chk("gap_rdy_at_done", CMD_RDY, 0);
    caps = 1;
    for (k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (CMD_RDY) break;
      if (!BYTE_VLD) caps++;
    end
    if (k == 20) tmo("gap_end");
    chk("gap_len", caps, G);
    tick();
`endif

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
